alu: RTL

//  Multi-cycle integer ALU; sits directly downstream of the control unit on the alu_* request/done handshake.

---
 rtl/alu_pkg.sv | 24 ++
 rtl/alu_divider.sv | 69 ++++++
 rtl/alu.sv | 137 +++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Purpose  : Shared ALU operation encoding and ALU sequencer state type.
// Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_MUL = 2'b10,
        ALU_DIV = 2'b11
    } alu_op_t;

    // Distinct labels from alu_op_t since both enums live in this package.
    typedef enum logic [1:0] {
        ALU_ST_IDLE = 2'b00,
        ALU_ST_MUL  = 2'b01,
        ALU_ST_DIV  = 2'b10
    } alu_state_t;

endpackage
`default_nettype wire

// File: rtl/alu_divider.sv
`default_nettype none
// ============================================================================
// Module   : alu_divider
// Purpose  : Restoring unsigned divider, one quotient bit per cycle, MSB first.
// Revision : 1.0 - initial release
// ============================================================================
module alu_divider #(
    parameter int REG_SIZE = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [REG_SIZE-1:0] dividend,
    input  logic [REG_SIZE-1:0] divisor,
    output logic [REG_SIZE-1:0] quotient,
    output logic                done
);

    localparam int                 c_cnt_w = $clog2(REG_SIZE + 1);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(REG_SIZE - 1);

    logic [REG_SIZE-1:0] r_rem;
    logic [REG_SIZE-1:0] r_quo;
    logic [REG_SIZE-1:0] r_dsr;
    logic [c_cnt_w-1:0]  r_cnt;
    logic                r_active;

    logic [REG_SIZE:0]   w_shift;
    logic [REG_SIZE:0]   w_diff;
    logic                w_fits;
    logic [REG_SIZE-1:0] w_rem_next;
    logic [REG_SIZE-1:0] w_quo_next;

    // The borrow out of the trial subtraction decides the quotient bit.
    assign w_shift    = {r_rem, r_quo[REG_SIZE-1]};
    assign w_diff     = w_shift - {1'b0, r_dsr};
    assign w_fits     = ~w_diff[REG_SIZE];
    assign w_rem_next = w_fits ? w_diff[REG_SIZE-1:0] : w_shift[REG_SIZE-1:0];
    assign w_quo_next = {r_quo[REG_SIZE-2:0], w_fits};

    // Final quotient is presented combinationally during the last iteration.
    assign quotient = w_quo_next;
    assign done     = r_active && (r_cnt == c_last);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rem    <= '0;
            r_quo    <= '0;
            r_dsr    <= '0;
            r_cnt    <= '0;
            r_active <= 1'b0;
        end else if (start) begin
            r_rem    <= '0;
            r_quo    <= dividend;
            r_dsr    <= divisor;
            r_cnt    <= '0;
            r_active <= 1'b1;
        end else if (r_active) begin
            r_rem <= w_rem_next;
            r_quo <= w_quo_next;
            r_cnt <= r_cnt + c_cnt_w'(1);
            if (r_cnt == c_last) begin
                r_active <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu.sv
`default_nettype none
// ============================================================================
// Module   : alu
// Purpose  : Multi-cycle unsigned ALU: 1-cycle ADD/SUB, iterative MUL and DIV.
// Revision : 1.0 - initial release
// ============================================================================
module alu
    import alu_pkg::*;
#(
    parameter int REG_SIZE = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          alu_operation,
    input  logic [REG_SIZE-1:0] alu_op1,
    input  logic [REG_SIZE-1:0] alu_op2,
    input  logic                alu_req,
    output logic                alu_done,
    output logic [REG_SIZE-1:0] alu_res,
    output logic                alu_busy,
    output logic                alu_dz
);

    localparam int                 c_cnt_w = $clog2(REG_SIZE + 1);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(REG_SIZE - 1);

    alu_state_t          r_state;
    logic [REG_SIZE-1:0] r_acc;
    logic [REG_SIZE-1:0] r_mcand;
    logic [REG_SIZE-1:0] r_mplier;
    logic [c_cnt_w-1:0]  r_cnt;

    alu_op_t             w_op;
    logic [REG_SIZE-1:0] w_acc_next;
    logic                w_div_start;
    logic [REG_SIZE-1:0] w_div_quo;
    logic                w_div_done;

    assign w_op        = alu_op_t'(alu_operation);
    assign w_acc_next  = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
    assign w_div_start = (r_state == ALU_ST_IDLE) && alu_req &&
                         (w_op == ALU_DIV) && (alu_op2 != '0);

    alu_divider #(
        .REG_SIZE (REG_SIZE)
    ) u_divider (
        .clk      (clk),
        .rst      (rst),
        .start    (w_div_start),
        .dividend (alu_op1),
        .divisor  (alu_op2),
        .quotient (w_div_quo),
        .done     (w_div_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ALU_ST_IDLE;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            alu_done <= 1'b0;
            alu_res  <= '0;
            alu_busy <= 1'b0;
            alu_dz   <= 1'b0;
        end else begin
            alu_done <= 1'b0;
            case (r_state)
                ALU_ST_IDLE: begin
                    if (alu_req) begin
                        case (w_op)
                            ALU_ADD: begin
                                alu_res  <= alu_op1 + alu_op2;
                                alu_dz   <= 1'b0;
                                alu_done <= 1'b1;
                            end
                            ALU_SUB: begin
                                alu_res  <= alu_op1 - alu_op2;
                                alu_dz   <= 1'b0;
                                alu_done <= 1'b1;
                            end
                            ALU_MUL: begin
                                r_acc    <= '0;
                                r_mcand  <= alu_op1;
                                r_mplier <= alu_op2;
                                r_cnt    <= '0;
                                alu_busy <= 1'b1;
                                r_state  <= ALU_ST_MUL;
                            end
                            ALU_DIV: begin
                                if (alu_op2 == '0) begin
                                    alu_res  <= '1;
                                    alu_dz   <= 1'b1;
                                    alu_done <= 1'b1;
                                end else begin
                                    alu_busy <= 1'b1;
                                    r_state  <= ALU_ST_DIV;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                ALU_ST_MUL: begin
                    // Shift-add, multiplier consumed LSB first; high bits fall off.
                    r_acc    <= w_acc_next;
                    r_mcand  <= {r_mcand[REG_SIZE-2:0], 1'b0};
                    r_mplier <= {1'b0, r_mplier[REG_SIZE-1:1]};
                    r_cnt    <= r_cnt + c_cnt_w'(1);
                    if (r_cnt == c_last) begin
                        alu_res  <= w_acc_next;
                        alu_dz   <= 1'b0;
                        alu_done <= 1'b1;
                        alu_busy <= 1'b0;
                        r_state  <= ALU_ST_IDLE;
                    end
                end
                ALU_ST_DIV: begin
                    if (w_div_done) begin
                        alu_res  <= w_div_quo;
                        alu_dz   <= 1'b0;
                        alu_done <= 1'b1;
                        alu_busy <= 1'b0;
                        r_state  <= ALU_ST_IDLE;
                    end
                end
                default: begin
                    alu_busy <= 1'b0;
                    r_state  <= ALU_ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
